iter_div: RTL and testbench

//   Multi-cycle iterative radix-2 integer divider for the EX stage; replaces the combinational Div unit.

---
 rtl/fu_pkg.sv | 14 +
 rtl/lzc.sv | 18 +
 rtl/iter_div.sv | 198 +++++++++++++++++++
 tb/tb_iter_div.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fu_pkg.sv
// Shared types and helpers for the iterative divider functional unit.
package fu_pkg;

   typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} div_state_t;

   // Widest operand neg_if handles; callers zero-extend in and truncate out.
   localparam int DIV_MAX_W = 64;

   function automatic logic [DIV_MAX_W-1:0] neg_if(input logic [DIV_MAX_W-1:0] x,
                                                   input logic                 c);
      return c ? (DIV_MAX_W'(0) - x) : x;
   endfunction

endpackage

// File: rtl/lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module lzc #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH+1)
) (
   input  logic [WIDTH-1:0] x,
   output logic [CNT_W-1:0] cnt
);

   // Scanning upward lets the highest set bit win.
   always_comb begin
      cnt = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (x[i]) cnt = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider, signed/unsigned quotient or remainder.
// Define DIV_EARLY_OUT_EN to skip the leading-zero iterations of the dividend.
module iter_div
   import fu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             is_unsigned,
   input  logic             use_mod,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             div_zero,
   output div_state_t       dbg_state
);

   // Handshake: a request is taken on a rising edge where in_valid & in_ready & ~flush;
   // a result is taken where out_valid & out_ready; flush overrides both and returns to IDLE.

   div_state_t       state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             div_zero_q, div_zero_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             uns_q, uns_d;
   logic             mod_q, mod_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH+1:0] shifted, diff;

   assign a_neg = ~uns_q & a_q[WIDTH-1];
   assign b_neg = ~uns_q & dvs_q[WIDTH-1];
   assign abs_a = WIDTH'(neg_if(DIV_MAX_W'(a_q), a_neg));
   assign abs_b = WIDTH'(neg_if(DIV_MAX_W'(dvs_q), b_neg));

`ifdef DIV_EARLY_OUT_EN
   logic [CNT_W-1:0] lz;

   lzc #(.WIDTH(WIDTH)) u_lzc (
      .x   (abs_a),
      .cnt (lz)
   );
`endif

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      div_zero_d  = div_zero_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      dvs_d       = dvs_q;
      uns_d       = uns_q;
      mod_d       = mod_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      // Extra top bit turns the trial subtraction's sign into the restore decision.
      shifted     = {rem_q, quo_q[WIDTH-1]};
      diff        = shifted - {2'b00, dvs_q};

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d        = dividend;
               dvs_d      = divisor;
               uns_d      = is_unsigned;
               mod_d      = use_mod;
               in_ready_d = 1'b0;
               state_d    = PREP;
            end
         end
         PREP: begin
            q_neg_d    = a_neg ^ b_neg;
            r_neg_d    = a_neg;
            dvs_d      = abs_b;
            rem_d      = '0;
            div_zero_d = (dvs_q == '0);
            if (dvs_q == '0) begin
               quo_d   = '1;
               rem_d   = {1'b0, a_q};
               q_neg_d = 1'b0;
               r_neg_d = 1'b0;
               state_d = FIX;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (abs_a == '0) begin
               quo_d   = '0;
               state_d = FIX;
            end else begin
               quo_d   = abs_a << lz;
               cnt_d   = CNT_W'(WIDTH) - lz;
               state_d = CALC;
            end
`else
            else begin
               quo_d   = abs_a;
               cnt_d   = CNT_W'(WIDTH);
               state_d = CALC;
            end
`endif
         end
         CALC: begin
            rem_d = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH+1]};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = FIX;
         end
         FIX: begin
            result_d    = mod_q ? WIDTH'(neg_if(DIV_MAX_W'(rem_q[WIDTH-1:0]), r_neg_q))
                                : WIDTH'(neg_if(DIV_MAX_W'(quo_q), q_neg_q));
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A cancelled op never publishes; the previous result stays in place.
      if (flush) begin
         state_d     = IDLE;
         in_ready_d  = 1'b1;
         out_valid_d = 1'b0;
         result_d    = result_q;
         div_zero_d  = div_zero_q;
         cnt_d       = '0;
         a_d         = a_q;
         dvs_d       = dvs_q;
         uns_d       = uns_q;
         mod_d       = mod_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         div_zero_q  <= 1'b0;
         cnt_q       <= '0;
         a_q         <= '0;
         dvs_q       <= '0;
         uns_q       <= 1'b0;
         mod_q       <= 1'b0;
         rem_q       <= '0;
         quo_q       <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         div_zero_q  <= div_zero_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         dvs_q       <= dvs_d;
         uns_q       <= uns_d;
         mod_q       <= mod_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign div_zero  = div_zero_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div: driver pushes expected results, a monitor pops them on each handshake.
module tb_iter_div;
   import fu_pkg::*;

   localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
   localparam int LAT_FULL = -1;
`else
   localparam int LAT_FULL = W + 2;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         is_unsigned = 1'b0;
   logic         use_mod = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic         div_zero;
   div_state_t   dbg_state;

   logic [W:0]   exp_q[$];
   int           checks = 0;
   int           failures = 0;

   iter_div #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .is_unsigned (is_unsigned),
      .use_mod     (use_mod),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .div_zero    (div_zero),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every completed handshake must match the oldest expectation.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'(result), 64'hdead);
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            chk("result", 64'(result), 64'(e[W-1:0]));
            chk("div_zero", 64'(div_zero), 64'(e[W]));
         end
      end
   end

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic uns, input logic md);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
      dividend    = a;
      divisor     = b;
      is_unsigned = uns;
      use_mod     = md;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid    = 1'b0;
      dividend    = $urandom;
      divisor     = $urandom;
      is_unsigned = 1'($urandom_range(0, 1));
      use_mod     = 1'($urandom_range(0, 1));
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic uns, input logic md,
                        input logic [W-1:0] er, input logic edz, input int lat);
      int n;
      exp_q.push_back({edz, er});
      start_op(a, b, uns, md);
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
      if (lat >= 0) chk("latency", 64'(n), 64'(lat));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  saw;
      reset = 1'b1;
      #3 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_div_zero", 64'(div_zero), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'(IDLE));
      reset = 1'b1;
      @(posedge clk); #1;

      // Signed and unsigned directed vectors.
      issue(32'd7,          32'd2,          1'b0, 1'b0, 32'd3,          1'b0, LAT_FULL);
      issue(32'd7,          32'd2,          1'b0, 1'b1, 32'd1,          1'b0, LAT_FULL);
      issue(32'hFFFF_FFF9,  32'd2,          1'b0, 1'b0, 32'hFFFF_FFFD,  1'b0, LAT_FULL);
      issue(32'hFFFF_FFF9,  32'd2,          1'b0, 1'b1, 32'hFFFF_FFFF,  1'b0, LAT_FULL);
      issue(32'd7,          32'hFFFF_FFFE,  1'b0, 1'b0, 32'hFFFF_FFFD,  1'b0, LAT_FULL);
      issue(32'd7,          32'hFFFF_FFFE,  1'b0, 1'b1, 32'd1,          1'b0, LAT_FULL);
      issue(32'hFFFF_FFFF,  32'd1,          1'b1, 1'b0, 32'hFFFF_FFFF,  1'b0, LAT_FULL);
      issue(32'hFFFF_FFFF,  32'd1,          1'b1, 1'b1, 32'd0,          1'b0, LAT_FULL);
      issue(32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0, 32'h8000_0000,  1'b0, LAT_FULL);
      issue(32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b1, 32'd0,          1'b0, LAT_FULL);
      issue(32'd100,        32'd7,          1'b1, 1'b1, 32'd2,          1'b0, LAT_FULL);
      issue(32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b0, 1'b0, 32'd14,         1'b0, LAT_FULL);
      issue(32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b0, 1'b1, 32'hFFFF_FFFE,  1'b0, LAT_FULL);
      issue(32'hFFFF_FFFF,  32'd2,          1'b1, 1'b0, 32'h7FFF_FFFF,  1'b0, LAT_FULL);
      issue(32'hFFFF_FFFF,  32'd2,          1'b0, 1'b0, 32'd0,          1'b0, LAT_FULL);
      issue(32'hFFFF_FFFF,  32'd2,          1'b0, 1'b1, 32'hFFFF_FFFF,  1'b0, LAT_FULL);
      issue(32'd0,          32'd5,          1'b1, 1'b0, 32'd0,          1'b0, LAT_FULL);

      // Divide by zero: all-ones quotient, untouched dividend as remainder.
      issue(32'h1234,       32'd0,          1'b1, 1'b0, 32'hFFFF_FFFF,  1'b1, 2);
      issue(32'h1234,       32'd0,          1'b1, 1'b1, 32'h1234,       1'b1, 2);
      issue(32'hFFFF_FFF8,  32'd0,          1'b0, 1'b1, 32'hFFFF_FFF8,  1'b1, 2);
      issue(32'hFFFF_FFF8,  32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF,  1'b1, 2);

      // Request presented together with flush is dropped.
      @(posedge clk); #1;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      chk("flush_accept_state", 64'(dbg_state), 64'(IDLE));
      chk("flush_accept_ready", 64'(in_ready), 64'd1);

      // Flush in the middle of CALC: nothing is emitted.
      start_op(32'd100, 32'd7, 1'b1, 1'b0);
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_state", 64'(dbg_state), 64'(IDLE));
      saw = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) saw = 1;
      end
      chk("flush_no_result", 64'(saw), 64'd0);
      issue(32'd9, 32'd3, 1'b0, 1'b0, 32'd3, 1'b0, LAT_FULL);

      // Backpressure in DONE: result holds, then exactly one handshake.
      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(32'd100, 32'd7, 1'b1, 1'b0, 32'd14, 1'b0, LAT_FULL);
      repeat (5) begin
         @(posedge clk); #1;
         chk("stall_result", 64'(result), 64'd14);
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_valid", 64'(out_valid), 64'd0);
      chk("release_in_ready", 64'(in_ready), 64'd1);
      chk("release_one_pop", 64'(exp_q.size()), 64'd0);

      // Flush coinciding with out_ready in DONE: consumed once, back to IDLE.
      out_ready = 1'b0;
      issue(32'd50, 32'd6, 1'b1, 1'b1, 32'd2, 1'b0, LAT_FULL);
      out_ready = 1'b1;
      flush     = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_done_state", 64'(dbg_state), 64'(IDLE));
      chk("flush_done_valid", 64'(out_valid), 64'd0);
      issue(32'hFFFF_FFEC, 32'd3, 1'b0, 1'b0, 32'hFFFF_FFFA, 1'b0, LAT_FULL);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
